// File: rtl/control_cmd_readrows.sv
// Handler for the "read rows" control command: parses a start-row header and a row count,
// then turns each following payload byte into one framebuffer RAM write, walking the panel right to left.
module control_cmd_readrows #(
  parameter int PIXEL_WIDTH     = 64,
  parameter int PIXEL_HEIGHT    = 32,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int ROW_BITS        = $clog2(PIXEL_HEIGHT),
  parameter int COL_BITS        = $clog2(PIXEL_WIDTH),
  parameter int PIX_BITS        = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          data_in,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] column,
  output logic [PIX_BITS-1:0] pixel,
  output logic [7:0]          data_out,
  output logic                ram_write_enable,
  output logic                ram_access_start,
  output logic                done
);

  localparam int ROW_BYTES = (ROW_BITS + 7) / 8;
  localparam logic [3:0]          HDR_LAST = 4'(ROW_BYTES - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(PIXEL_WIDTH - 1);
  localparam logic [PIX_BITS-1:0] PIX_LAST = PIX_BITS'(BYTES_PER_PIXEL - 1);

  typedef enum logic [1:0] {S_ROW, S_COUNT, S_DATA, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] hdr_q, hdr_d;
  logic [3:0]          hdr_cnt_q, hdr_cnt_d;
  logic [7:0]          rows_left_q, rows_left_d;

  // cur_* points at the byte the next enable writes; row_q/col_q/pix_q show the byte just written.
  logic [ROW_BITS-1:0] cur_row_q, cur_row_d;
  logic [COL_BITS-1:0] cur_col_q, cur_col_d;
  logic [PIX_BITS-1:0] cur_pix_q, cur_pix_d;

  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [PIX_BITS-1:0] pix_q, pix_d;
  logic [7:0]          data_q, data_d;
  logic                we_q, we_d;
  logic                as_q, as_d;
  logic                done_q, done_d;

  assign row              = row_q;
  assign column           = col_q;
  assign pixel            = pix_q;
  assign data_out         = data_q;
  assign ram_write_enable = we_q;
  assign ram_access_start = as_q;
  assign done             = done_q;

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    hdr_d       = hdr_q;
    hdr_cnt_d   = hdr_cnt_q;
    rows_left_d = rows_left_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    cur_pix_d   = cur_pix_q;
    row_d       = row_q;
    col_d       = col_q;
    pix_d       = pix_q;
    data_d      = data_q;
    we_d        = we_q;
    as_d        = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      S_ROW: begin
        if (enable) begin
          // Header bytes beyond the row address width fall off the top of the shift.
          hdr_d = ROW_BITS'({hdr_q, data_in});
          if (hdr_cnt_q == HDR_LAST) begin
            hdr_cnt_d = '0;
            state_d   = S_COUNT;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 4'd1;
          end
        end
      end

      S_COUNT: begin
        if (enable) begin
          rows_left_d = data_in;
          cur_row_d   = hdr_q;
          cur_col_d   = COL_LAST;
          cur_pix_d   = PIX_LAST;
          row_d       = hdr_q;
          col_d       = COL_LAST;
          pix_d       = PIX_LAST;
          we_d        = 1'b1;
          state_d     = S_DATA;
        end
      end

      S_DATA: begin
        if (enable) begin
          data_d = data_in;
          as_d   = 1'b1;
          row_d  = cur_row_q;
          col_d  = cur_col_q;
          pix_d  = cur_pix_q;
          if (cur_pix_q != '0) begin
            cur_pix_d = cur_pix_q - 1'b1;
          end else begin
            cur_pix_d = PIX_LAST;
            if (cur_col_q != '0) begin
              cur_col_d = cur_col_q - 1'b1;
            end else begin
              // Row finished; power-of-two height makes the increment wrap for free.
              cur_col_d = COL_LAST;
              cur_row_d = cur_row_q + 1'b1;
              if (rows_left_q == 8'd0) begin
                state_d = S_DONE;
              end else begin
                rows_left_d = rows_left_q - 8'd1;
              end
            end
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        we_d    = 1'b0;
        hdr_d   = '0;
        state_d = S_ROW;
      end

      default: state_d = S_ROW;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= S_ROW;
      hdr_q       <= '0;
      hdr_cnt_q   <= '0;
      rows_left_q <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      cur_pix_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pix_q       <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      as_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      hdr_cnt_q   <= hdr_cnt_d;
      rows_left_q <= rows_left_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      cur_pix_q   <= cur_pix_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pix_q       <= pix_d;
      data_q      <= data_d;
      we_q        <= we_d;
      as_q        <= as_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_control_cmd_readrows.sv
// Bench for control_cmd_readrows on a 4x16 panel with 2 bytes per pixel: a stream-position model
// predicts every output each cycle, and literal expectations pin the model on the directed streams.
module tb_control_cmd_readrows;

  localparam int W  = 4;
  localparam int H  = 16;
  localparam int B  = 2;
  localparam int RB = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_in;
  logic [3:0] row;
  logic [1:0] column;
  logic [0:0] pixel;
  logic [7:0] data_out;
  logic       ram_write_enable;
  logic       ram_access_start;
  logic       done;

  control_cmd_readrows #(
    .PIXEL_WIDTH    (W),
    .PIXEL_HEIGHT   (H),
    .BYTES_PER_PIXEL(B)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .data_in         (data_in),
    .row             (row),
    .column          (column),
    .pixel           (pixel),
    .data_out        (data_out),
    .ram_write_enable(ram_write_enable),
    .ram_access_start(ram_access_start),
    .done            (done)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position within the command stream decides what each consumed byte means.
  int   pos = 0, hdr = 0, n = 0, start = 0, k;
  bit   wait_done = 1'b0;
  logic exp_as = 1'b0, exp_done = 1'b0, exp_we = 1'b0;
  int   exp_row = 0, exp_col = 0, exp_pix = 0, exp_data = 0;

  always @(posedge clk) begin
    exp_as   = 1'b0;
    exp_done = 1'b0;
    if (reset) begin
      pos = 0; hdr = 0; wait_done = 1'b0; exp_we = 1'b0;
      exp_row = 0; exp_col = 0; exp_pix = 0; exp_data = 0;
    end else if (wait_done) begin
      wait_done = 1'b0; exp_done = 1'b1; exp_we = 1'b0; pos = 0; hdr = 0;
    end else if (enable) begin
      if (pos < RB) begin
        hdr = hdr * 256 + int'(data_in);
      end else if (pos == RB) begin
        n = int'(data_in); start = hdr % H;
        exp_row = start; exp_col = W - 1; exp_pix = B - 1; exp_we = 1'b1;
      end else begin
        k        = pos - RB - 1;
        exp_as   = 1'b1;
        exp_data = int'(data_in);
        exp_row  = (start + k / (W * B)) % H;
        exp_col  = W - 1 - (k / B) % W;
        exp_pix  = B - 1 - k % B;
        if (k == (n + 1) * W * B - 1) wait_done = 1'b1;
      end
      pos++;
    end
  end

  typedef struct packed {
    logic [3:0] r;
    logic [1:0] c;
    logic       p;
    logic [7:0] d;
  } wr_t;

  wr_t log_q[$];
  int  done_cnt = 0;

  always @(negedge clk) begin
    check("access_start", 32'(ram_access_start), 32'(exp_as));
    check("done",         32'(done),             32'(exp_done));
    check("write_enable", 32'(ram_write_enable), 32'(exp_we));
    check("row",          32'(row),              32'(exp_row));
    check("column",       32'(column),           32'(exp_col));
    check("pixel",        32'(pixel),            32'(exp_pix));
    check("data_out",     32'(data_out),         32'(exp_data));
    if (ram_access_start) log_q.push_back('{row, column, pixel, data_out});
    if (done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    enable  = 1'b1;
    data_in = b;
    tick();
    enable  = 1'b0;
    repeat (gap) tick();
  endtask

  // Header, count, then (cnt+1)*W*B incrementing bytes from base; one idle cycle covers the done state.
  task automatic send_cmd(input logic [7:0] start_row, input logic [7:0] cnt,
                          input logic [7:0] base, input int gap);
    send_byte(start_row, gap);
    send_byte(cnt, gap);
    for (int i = 0; i < (int'(cnt) + 1) * W * B; i++) send_byte(base + 8'(i), gap);
    tick();
  endtask

  function automatic logic [31:0] wr(input int r, input int c, input int p, input int d);
    wr_t w;
    w = '{4'(r), 2'(c), 1'(p), 8'(d)};
    return 32'(w);
  endfunction

  wr_t fast_q[$];
  int  d0;

  initial begin
    reset = 1'b1; enable = 1'b0; data_in = 8'h00;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_row",  32'(row), 32'd0);
    check("reset_we",   32'(ram_write_enable), 32'd0);
    check("reset_done", 32'(done_cnt), 32'd0);

    // Single row at row 5.
    log_q.delete(); d0 = done_cnt;
    send_cmd(8'h05, 8'd0, 8'h10, 0);
    repeat (3) tick();
    check("t1_count", 32'(log_q.size()), 32'd8);
    check("t1_first", 32'(log_q[0]), wr(5, 3, 1, 8'h10));
    check("t1_second", 32'(log_q[1]), wr(5, 3, 0, 8'h11));
    check("t1_third", 32'(log_q[2]), wr(5, 2, 1, 8'h12));
    check("t1_last",  32'(log_q[7]), wr(5, 0, 0, 8'h17));
    check("t1_done",  32'(done_cnt - d0), 32'd1);

    // Two rows starting at 15 wrap to row 0.
    log_q.delete(); d0 = done_cnt;
    send_cmd(8'h0F, 8'd1, 8'h20, 0);
    repeat (3) tick();
    check("t2_count", 32'(log_q.size()), 32'd16);
    check("t2_row15_last", 32'(log_q[7]), wr(15, 0, 0, 8'h27));
    check("t2_wrap_first", 32'(log_q[8]), wr(0, 3, 1, 8'h28));
    check("t2_done", 32'(done_cnt - d0), 32'd1);

    // Header bits above the row width are ignored.
    log_q.delete();
    send_cmd(8'hF3, 8'd0, 8'h30, 0);
    repeat (3) tick();
    check("t3_row3", 32'(log_q[0]), wr(3, 3, 1, 8'h30));

    // Same stream back-to-back and with an enable every 16 clocks.
    log_q.delete();
    send_cmd(8'h0A, 8'd1, 8'h40, 0);
    repeat (3) tick();
    fast_q = log_q;
    log_q.delete(); d0 = done_cnt;
    send_cmd(8'h0A, 8'd1, 8'h40, 15);
    repeat (3) tick();
    check("t4_count", 32'(log_q.size()), 32'd16);
    check("t4_done", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 16; i++) check("t4_same_seq", 32'(log_q[i]), 32'(fast_q[i]));
    check("t4_row11", 32'(log_q[15]), wr(11, 0, 0, 8'h4F));

    // Reset after three data bytes abandons the command without done.
    log_q.delete(); d0 = done_cnt;
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    log_q.delete();
    send_cmd(8'h02, 8'd0, 8'h50, 0);
    repeat (3) tick();
    check("t5_count", 32'(log_q.size()), 32'd8);
    check("t5_first", 32'(log_q[0]), wr(2, 3, 1, 8'h50));
    check("t5_last",  32'(log_q[7]), wr(2, 0, 0, 8'h57));
    check("t5_done", 32'(done_cnt - d0), 32'd1);

    // Two commands back to back.
    log_q.delete(); d0 = done_cnt;
    send_cmd(8'h01, 8'd0, 8'h60, 0);
    send_cmd(8'h07, 8'd0, 8'h70, 0);
    repeat (3) tick();
    check("t6_count", 32'(log_q.size()), 32'd16);
    check("t6_done2", 32'(done_cnt - d0), 32'd2);
    check("t6_first1", 32'(log_q[0]), wr(1, 3, 1, 8'h60));
    check("t6_first2", 32'(log_q[8]), wr(7, 3, 1, 8'h70));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
